core_ldst_multiple_seq: RTL and testbench

CORE_LDST_MULTIPLE_SEQ -- requirements
Module: core_ldst_multiple_seq

---
 rtl/core_ldst_multiple_seq_if.sv | 35 +++
 rtl/core_ldst_multiple_seq.sv | 185 ++++++++++++++++++
 tb/tb_core_ldst_multiple_seq.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ldst_multiple_seq_if.sv
// rtl/core_ldst_multiple_seq_if.sv - beat handshake bus between the LDM/STM sequencer and the memory unit
//
// Signals:
//   xfer_valid  sequencer -> memory  beat offered
//   xfer_ready  memory -> sequencer  beat accepted this cycle
//   xfer_reg    sequencer -> memory  register number of the beat
//   xfer_addr   sequencer -> memory  word-aligned beat address
//   xfer_last   sequencer -> memory  beat is the final one of the sequence
// Modports: master = sequencer side, slave = memory side.

interface core_ldst_multiple_seq_if #(
  parameter int ADDR_W = 32
);
  logic              xfer_valid;
  logic              xfer_ready;
  logic [3:0]        xfer_reg;
  logic [ADDR_W-1:0] xfer_addr;
  logic              xfer_last;

  modport master (
    output xfer_valid,
    output xfer_reg,
    output xfer_addr,
    output xfer_last,
    input  xfer_ready
  );

  modport slave (
    input  xfer_valid,
    input  xfer_reg,
    input  xfer_addr,
    input  xfer_last,
    output xfer_ready
  );
endinterface

// File: rtl/core_ldst_multiple_seq.sv
// rtl/core_ldst_multiple_seq.sv - LDM/STM multiple-register beat sequencer
//
// Ports:
//   clk        in   core clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   decoded LDM/STM issued this cycle (honoured only when idle)
//   reg_list   in   16-bit register bitmap, bit i = r{i}
//   increment  in   1 = IA/IB, 0 = DA/DB
//   pre_index  in   1 = IB/DB, 0 = IA/DA
//   base       in   base register value Rn
//   abort      in   flush / data abort, cancels the sequence without a done pulse
//   busy       out  sequence in progress
//   xfer       bus  beat handshake (master side): valid/ready/reg/addr/last
//   done       out  one-cycle completion pulse
//   wb_value   out  Rn writeback value, valid while done=1

module core_ldst_multiple_seq #(
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                reg_list,
  input  logic                       increment,
  input  logic                       pre_index,
  input  logic [ADDR_W-1:0]          base,
  input  logic                       abort,
  output logic                       busy,
  core_ldst_multiple_seq_if.master   xfer,
  output logic                       done,
  output logic [ADDR_W-1:0]          wb_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [15:0]       remain;
  logic              busy_q;
  logic              valid_q;
  logic [3:0]        reg_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              done_q;
  logic [ADDR_W-1:0] wb_q;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

  // Scans downwards so the last hit is the lowest set bit.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  logic [4:0]        start_cnt;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] wb_start;
  logic [15:0]       remain_next;
  logic              fire;

  assign start_cnt = popcount16(reg_list);
  // 4*n, truncated to the address width so everything wraps modulo 2^ADDR_W.
  assign span      = ADDR_W'({start_cnt, 2'b00});
  assign wb_start  = increment ? (base + span) : (base - span);

  // Beats always go out in ascending address order, so the sequence start is
  // the lowest address of the block regardless of direction.
  always_comb begin
    first_addr = base;
    case ({increment, pre_index})
      2'b10:   first_addr = base;
      2'b11:   first_addr = base + ADDR_W'(4);
      2'b00:   first_addr = base - span + ADDR_W'(4);
      default: first_addr = base - span;
    endcase
  end

  // Clearing the lowest set bit removes exactly the register just issued.
  assign remain_next = remain & (remain - 16'd1);
  assign fire        = valid_q && xfer.xfer_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      remain  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      wb_q    <= '0;
    end else if (abort) begin
      // Abort wins over any same-cycle transfer or start.
      state   <= IDLE;
      remain  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remain <= reg_list;
            wb_q   <= wb_start;
            busy_q <= 1'b1;
            if (reg_list == 16'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= XFER;
              valid_q <= 1'b1;
              reg_q   <= lowest_set(reg_list);
              addr_q  <= first_addr;
              last_q  <= (start_cnt == 5'd1);
            end
          end
        end

        XFER: begin
          if (fire) begin
            if (last_q) begin
              state   <= DONE;
              remain  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              remain <= remain_next;
              reg_q  <= lowest_set(remain_next);
              addr_q <= addr_q + ADDR_W'(4);
              last_q <= single_bit(remain_next);
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          remain  <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign xfer.xfer_valid = valid_q;
  assign xfer.xfer_reg   = reg_q;
  assign xfer.xfer_addr  = addr_q;
  assign xfer.xfer_last  = last_q;
  assign done           = done_q;
  assign wb_value       = wb_q;

endmodule

// File: tb/tb_core_ldst_multiple_seq.sv
// tb/tb_core_ldst_multiple_seq.sv - self-checking bench for core_ldst_multiple_seq
module tb_core_ldst_multiple_seq;
  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [15:0]   reg_list;
  logic          increment;
  logic          pre_index;
  logic [AW-1:0] base;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] wb_value;

  core_ldst_multiple_seq_if #(.ADDR_W(AW)) xfer_bus ();

  core_ldst_multiple_seq #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reg_list  (reg_list),
    .increment (increment),
    .pre_index (pre_index),
    .base      (base),
    .abort     (abort),
    .busy      (busy),
    .xfer      (xfer_bus.master),
    .done      (done),
    .wb_value  (wb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    r;
    logic [AW-1:0] a;
    logic          l;
  } beat_t;

  int            tests = 0;
  int            fails = 0;

  beat_t         m_q[$];
  logic          m_done;
  logic [AW-1:0] m_wb;
  beat_t         obs[$];
  logic [AW-1:0] obs_wb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list straight from the addressing rules: the block spans
  // 4*n bytes, beats climb by 4 from its lowest word in register order.
  task automatic plan_seq(input logic inc, input logic pre, input logic [AW-1:0] b,
                          input logic [15:0] list);
    int            n;
    int            k;
    logic [AW-1:0] span;
    logic [AW-1:0] a;
    beat_t         bt;
    n    = $countones(list);
    span = AW'(n * 4);
    if (inc) a = pre ? b + 4 : b;
    else     a = pre ? b - span : b - span + 4;
    m_q.delete();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        bt.r = 4'(i);
        bt.a = a;
        bt.l = (k == n - 1);
        m_q.push_back(bt);
        a = a + 4;
        k++;
      end
    end
    m_wb   = inc ? b + span : b - span;
    m_done = (n == 0);
  endtask

  // Compare process: checks every cycle mid-period, then advances the model
  // by what the next rising edge must do.
  always @(negedge clk) begin
    beat_t bt;
    if (!rst_n) begin
      m_q.delete();
      m_done = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_valid", xfer_bus.xfer_valid, 0);
      check("rst_done", done, 0);
      check("rst_addr", xfer_bus.xfer_addr, 0);
    end else begin
      check("busy", busy, (m_q.size() > 0) || m_done);
      check("xfer_valid", xfer_bus.xfer_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("xfer_reg", xfer_bus.xfer_reg, m_q[0].r);
        check("xfer_addr", xfer_bus.xfer_addr, m_q[0].a);
        check("xfer_last", xfer_bus.xfer_last, m_q[0].l);
      end
      check("done", done, m_done);
      if (m_done) check("wb_value", wb_value, m_wb);
      if (done) obs_wb.push_back(wb_value);

      if (abort) begin
        m_q.delete();
        m_done = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_q.size() > 0) begin
        if (xfer_bus.xfer_ready) begin
          bt.r = xfer_bus.xfer_reg;
          bt.a = xfer_bus.xfer_addr;
          bt.l = xfer_bus.xfer_last;
          obs.push_back(bt);
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1'b1;
        end
      end else if (start) begin
        plan_seq(increment, pre_index, base, reg_list);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic inc, input logic pre, input logic [AW-1:0] b,
                       input logic [15:0] list);
    tick();
    start     = 1'b1;
    increment = inc;
    pre_index = pre;
    base      = b;
    reg_list  = list;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    int cyc;
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      if (toggle) xfer_bus.xfer_ready = ~xfer_bus.xfer_ready;
      cyc++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", cyc);
    end
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [3:0] r,
                           input logic [AW-1:0] a, input logic l);
    if (idx < obs.size()) begin
      check({tag, "_reg"}, obs[idx].r, r);
      check({tag, "_addr"}, obs[idx].a, a);
      check({tag, "_last"}, obs[idx].l, l);
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: beat %0d missing, got %0d beats", tag, idx, obs.size());
    end
  endtask

  task automatic check_wb(input string tag, input logic [AW-1:0] w);
    check({tag, "_done_cnt"}, obs_wb.size(), 1);
    if (obs_wb.size() > 0) check({tag, "_wb"}, obs_wb[0], w);
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_wb.delete();
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    start     = 1'b0;
    reg_list  = '0;
    increment = 1'b0;
    pre_index = 1'b0;
    base      = '0;
    abort     = 1'b0;
    xfer_bus.xfer_ready = 1'b1;

    // Pin the model with hand-computed values.
    plan_seq(1'b1, 1'b0, 32'h1000, 16'h8011);
    check("pin_ia_n", m_q.size(), 3);
    check("pin_ia_r2", m_q[2].r, 4'd15);
    check("pin_ia_a2", m_q[2].a, 32'h1008);
    check("pin_ia_l2", m_q[2].l, 1);
    check("pin_ia_wb", m_wb, 32'h100C);
    plan_seq(1'b0, 1'b1, 32'h2000, 16'h000F);
    check("pin_db_a0", m_q[0].a, 32'h1FF0);
    check("pin_db_a3", m_q[3].a, 32'h1FFC);
    check("pin_db_wb", m_wb, 32'h1FF0);
    plan_seq(1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0003);
    check("pin_wrap_a1", m_q[1].a, 32'h0);
    check("pin_wrap_wb", m_wb, 32'h4);
    m_q.delete();
    m_done = 1'b0;

    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_wb", wb_value, 0);
    rst_n = 1'b1;
    tick();

    // IA, ready held high.
    clear_obs();
    issue(1'b1, 1'b0, 32'h1000, 16'h8011);
    wait_idle(1'b0);
    check("ia_nbeats", obs.size(), 3);
    check_obs("ia_b0", 0, 4'd0, 32'h1000, 1'b0);
    check_obs("ia_b1", 1, 4'd4, 32'h1004, 1'b0);
    check_obs("ia_b2", 2, 4'd15, 32'h1008, 1'b1);
    check_wb("ia", 32'h100C);

    // DB with ready toggling.
    clear_obs();
    issue(1'b0, 1'b1, 32'h2000, 16'h000F);
    wait_idle(1'b1);
    xfer_bus.xfer_ready = 1'b1;
    check("db_nbeats", obs.size(), 4);
    check_obs("db_b0", 0, 4'd0, 32'h1FF0, 1'b0);
    check_obs("db_b3", 3, 4'd3, 32'h1FFC, 1'b1);
    check_wb("db", 32'h1FF0);

    // Empty list.
    clear_obs();
    issue(1'b1, 1'b0, 32'h40, 16'h0000);
    wait_idle(1'b0);
    check("empty_nbeats", obs.size(), 0);
    check_wb("empty", 32'h40);

    // IB with abort on the second accepted beat, then a DA sequence.
    clear_obs();
    issue(1'b1, 1'b1, 32'h3000, 16'h00F0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_nbeats", obs.size(), 1);
    check("abort_no_done", obs_wb.size(), 0);
    clear_obs();
    issue(1'b0, 1'b0, 32'h100, 16'h0005);
    wait_idle(1'b0);
    check_obs("da_b0", 0, 4'd0, 32'hFC, 1'b0);
    check_obs("da_b1", 1, 4'd2, 32'h100, 1'b1);
    check_wb("da", 32'hF8);

    // start while busy and start in the DONE cycle are both ignored.
    clear_obs();
    xfer_bus.xfer_ready = 1'b0;
    issue(1'b1, 1'b0, 32'h500, 16'h0006);
    start = 1'b1; reg_list = 16'hFFFF; base = 32'h0; increment = 1'b0;
    tick();
    start = 1'b0;
    tick();
    xfer_bus.xfer_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    check("seen_done", done, 1);
    start = 1'b1; reg_list = 16'h0001; base = 32'h900; increment = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    check("busy_nbeats", obs.size(), 2);
    check_obs("busy_b0", 0, 4'd1, 32'h500, 1'b0);
    check_obs("busy_b1", 1, 4'd2, 32'h504, 1'b1);
    check_wb("busy", 32'h508);

    // Asynchronous reset mid-sequence, then a wrapping IA sequence.
    issue(1'b1, 1'b0, 32'h10, 16'h00FF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", xfer_bus.xfer_valid, 0);
    check("arst_last", xfer_bus.xfer_last, 0);
    check("arst_reg", xfer_bus.xfer_reg, 0);
    check("arst_addr", xfer_bus.xfer_addr, 0);
    check("arst_done", done, 0);
    check("arst_wb", wb_value, 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
    issue(1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0003);
    wait_idle(1'b0);
    check_obs("wrap_b0", 0, 4'd0, 32'hFFFF_FFFC, 1'b0);
    check_obs("wrap_b1", 1, 4'd1, 32'h0000_0000, 1'b1);
    check_wb("wrap", 32'h4);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
